wptr_full_level: RTL and testbench

Write-domain pointer and status block for the asynchronous FIFO, parametrised in depth and almost-full margin. It owns the binary and Gray write pointers and the RAM write address. Using the Gray read pointer already synchronised into the write domain, it produces registered full, almost-full and fill-level outputs. It also holds a sticky overflow flag for writes attempted while full.

---
 rtl/wptr_full_level.sv | 73 +++++++
 tb/tb_wptr_full_level.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wptr_full_level.sv
// Write-domain pointer and status block for an asynchronous FIFO: binary/Gray write pointers,
// RAM write address, and registered full, almost-full, fill-level and sticky overflow flags.
module wptr_full_level #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic                  wovf_clr,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] lvl_next;
    logic [PW-1:0] full_ptr;
    logic          push;

    assign push       = winc & ~wfull;
    assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, push};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Gray-to-binary: XOR prefix from the MSB down.
    always_comb begin
        rbin = '0;
        rbin[PW-1] = wq2_rptr[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    assign lvl_next = wbin_next - rbin;
    assign full_ptr = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == full_ptr);
            walmost_full <= (lvl_next >= AF_THRESH);
            wlevel       <= lvl_next;
            // Set has priority over a simultaneous clear.
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end else if (wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

    assign waddr = wbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed self-checking bench for wptr_full_level (ADDR_WIDTH=3, AF_MARGIN=2).
module tb_wptr_full_level;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic       wovf_clr;
    logic [3:0] wq2_rptr;
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       woverflow;

    int checks = 0;
    int fails  = 0;

    wptr_full_level #(
        .ADDR_WIDTH(3),
        .AF_MARGIN (2)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .winc        (winc),
        .wovf_clr    (wovf_clr),
        .wq2_rptr    (wq2_rptr),
        .wptr        (wptr),
        .waddr       (waddr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".wptr"}, 32'(wptr), 32'd0);
        check({tag, ".waddr"}, 32'(waddr), 32'd0);
        check({tag, ".wfull"}, 32'(wfull), 32'd0);
        check({tag, ".walmost_full"}, 32'(walmost_full), 32'd0);
        check({tag, ".wlevel"}, 32'(wlevel), 32'd0);
        check({tag, ".woverflow"}, 32'(woverflow), 32'd0);
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return (b >> 1) ^ b;
    endfunction

    logic [3:0] wb_model;
    logic [3:0] prev_wptr;

    initial begin
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = 4'd0;
        #12;
        check_zero("in_reset");
        wrst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_zero("idle10");

        // Fill eight entries with the read pointer parked at zero.
        for (int i = 0; i < 8; i++) begin
            winc = 1'b1;
            check($sformatf("fill_waddr%0d", i), 32'(waddr), 32'(i));
            tick();
            check($sformatf("fill_level%0d", i + 1), 32'(wlevel), 32'(i + 1));
            if (i == 4) check("fill_af_at5", 32'(walmost_full), 32'd0);
            if (i == 5) check("fill_af_at6", 32'(walmost_full), 32'd1);
            if (i == 6) check("fill_nofull_at7", 32'(wfull), 32'd0);
        end
        check("full_flag", 32'(wfull), 32'd1);
        check("full_wptr", 32'(wptr), 32'hC);

        // Overflow attempts while full.
        tick();
        check("ovf1_wptr", 32'(wptr), 32'hC);
        check("ovf1_flag", 32'(woverflow), 32'd1);
        tick();
        check("ovf2_wptr", 32'(wptr), 32'hC);
        check("ovf2_level", 32'(wlevel), 32'd8);
        winc     = 1'b0;
        wovf_clr = 1'b1;
        tick();
        check("ovf_clr", 32'(woverflow), 32'd0);
        winc = 1'b1;
        tick();
        check("ovf_set_wins", 32'(woverflow), 32'd1);
        check("ovf_set_wptr", 32'(wptr), 32'hC);
        winc = 1'b0;
        tick();
        check("ovf_clr2", 32'(woverflow), 32'd0);
        wovf_clr = 1'b0;

        // Release: read pointer advances to binary 1, then binary 5.
        wq2_rptr = 4'b0001;
        tick();
        check("rel_full", 32'(wfull), 32'd0);
        check("rel_level", 32'(wlevel), 32'd7);
        check("rel_af", 32'(walmost_full), 32'd1);
        wq2_rptr = 4'b0111;
        tick();
        check("drain_level", 32'(wlevel), 32'd3);
        check("drain_af", 32'(walmost_full), 32'd0);

        // Wrap: 20 pushes with the reader trailing three entries behind.
        wb_model  = 4'd8;
        prev_wptr = wptr;
        for (int i = 0; i < 20; i++) begin
            winc     = 1'b1;
            wq2_rptr = gray(wb_model - 4'd3);
            tick();
            wb_model = wb_model + 4'd1;
            check($sformatf("wrap_wptr%0d", i), 32'(wptr), 32'(gray(wb_model)));
            check($sformatf("wrap_onebit%0d", i), $countones(wptr ^ prev_wptr), 32'd1);
            check($sformatf("wrap_nofull%0d", i), 32'(wfull), 32'd0);
            check($sformatf("wrap_level%0d", i), 32'(wlevel), 32'd4);
            prev_wptr = wptr;
        end
        check("wrap_waddr", 32'(waddr), 32'd4);

        // Build level 5, then push and read together.
        wq2_rptr = gray(4'd8);
        tick();
        check("lvl5", 32'(wlevel), 32'd5);
        wq2_rptr = gray(4'd9);
        tick();
        check("simul_level", 32'(wlevel), 32'd5);
        check("simul_af", 32'(walmost_full), 32'd0);
        check("simul_waddr", 32'(waddr), 32'd6);

        // Asynchronous reset in the middle of a burst.
        tick();
        #2;
        wrst_n = 1'b0;
        #1;
        check_zero("async_rst");
        winc     = 1'b0;
        wq2_rptr = 4'd0;
        @(negedge wclk);
        wrst_n = 1'b1;
        tick();
        check_zero("post_rst");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
